// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures period and high time of an asynchronous
// monitored clock in clk cycles, flags out-of-tolerance periods and a
// clock that has stopped toggling.
//
// state | meaning
// IDLE  | monitor disabled, counter held at 0
// ARM   | waiting for the first mon_clk rise, no measurement yet
// MEAS  | counting between rises, reporting each completed period
module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             period_err,
  output logic             stuck,
  output logic [15:0]      meas_count
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0] EXP_C  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_C  = (CNT_W+1)'(TOL);

  state_t              state;
  logic                mon_s1;
  logic                mon_s;
  logic                mon_s_d;
  logic                rise;
  logic                fall;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] abs_diff;
  logic                out_of_tol;

  // Two-flop synchroniser for mon_clk plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_s1  <= 1'b0;
      mon_s   <= 1'b0;
      mon_s_d <= 1'b0;
    end else begin
      mon_s1  <= mon_clk;
      mon_s   <= mon_s1;
      mon_s_d <= mon_s;
    end
  end

  // Edge strobes, saturating increment and the tolerance compare; the extra
  // sign bit keeps cnt - EXP_PERIOD exact over the whole counter range.
  always_comb begin
    rise       = mon_s & ~mon_s_d;
    fall       = ~mon_s & mon_s_d;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    diff       = $signed({1'b0, cnt}) - EXP_C;
    abs_diff   = (diff < 0) ? -diff : diff;
    out_of_tol = (abs_diff > TOL_C);
  end

  // Measurement FSM with registered outputs; a new error overrides err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period_o   <= '0;
      high_o     <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
      meas_count <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (err_clr) begin
        period_err <= 1'b0;
      end
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              stuck <= 1'b0;
              state <= MEAS;
            end else if (cnt >= TIMEOUT_C) begin
              stuck <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEAS: begin
            if (rise) begin
              period_o   <= cnt;
              meas_valid <= 1'b1;
              meas_count <= meas_count + 16'd1;
              cnt        <= CNT_ONE;
              if (out_of_tol) begin
                period_err <= 1'b1;
              end
            end else begin
              if (fall) begin
                high_o <= cnt;
              end
              if (cnt >= TIMEOUT_C) begin
                stuck <= 1'b1;
                cnt   <= '0;
                state <= ARM;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: default instance plus a slow-clock
// instance and a narrow-counter instance.
module tb_clk_period_monitor;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic err_clr;
  logic mon_clk;
  logic en_slow;
  logic mon_slow;
  logic en_small;
  logic mon_small;

  logic [15:0] period_o;
  logic [15:0] high_o;
  logic        meas_valid;
  logic        period_err;
  logic        stuck;
  logic [15:0] meas_count;

  logic [15:0] s_period;
  logic [15:0] s_high;
  logic        s_valid;
  logic        s_err;
  logic        s_stuck;
  logic [15:0] s_count;

  logic [7:0]  m_period;
  logic [7:0]  m_high;
  logic        m_valid;
  logic        m_err;
  logic        m_stuck;
  logic [15:0] m_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mv_cnt   = 0;
  int nom_bad  = 0;
  int first_valid = -1;
  int last_period = 0;
  int last_high   = 0;
  bit in_nom = 1'b0;

  clk_period_monitor u_dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .mon_clk(mon_clk),
    .period_o(period_o), .high_o(high_o), .meas_valid(meas_valid),
    .period_err(period_err), .stuck(stuck), .meas_count(meas_count)
  );

  clk_period_monitor #(.TIMEOUT(2000)) u_slow (
    .clk(clk), .rst(rst), .en(en_slow), .err_clr(1'b0), .mon_clk(mon_slow),
    .period_o(s_period), .high_o(s_high), .meas_valid(s_valid),
    .period_err(s_err), .stuck(s_stuck), .meas_count(s_count)
  );

  clk_period_monitor #(.CNT_W(8), .TIMEOUT(200)) u_small (
    .clk(clk), .rst(rst), .en(en_small), .err_clr(1'b0), .mon_clk(mon_small),
    .period_o(m_period), .high_o(m_high), .meas_valid(m_valid),
    .period_err(m_err), .stuck(m_stuck), .meas_count(m_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every measurement pulse of the default instance.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (mv_cnt == 0) first_valid = cyc;
      mv_cnt++;
      last_period = int'(period_o);
      last_high   = int'(high_o);
      if (in_nom && (period_o != 16'd10 || high_o != 16'd5)) nom_bad++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_period(input int h, input int l);
    mon_clk = 1'b1;
    tick(h);
    mon_clk = 1'b0;
    tick(l);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_rise;
    int n;
    int mv_s;
    int mv0;
    int mc_d;

    rst = 1'b0; en = 1'b0; err_clr = 1'b0; mon_clk = 1'b0;
    en_slow = 1'b0; mon_slow = 1'b0; en_small = 1'b0; mon_small = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {period_o, high_o, meas_count, meas_valid, period_err, stuck}, 64'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    en = 1'b1;
    tick(3);

    // nominal 5/5 clock, 20 periods
    in_nom = 1'b1;
    mon_clk = 1'b1;
    t_rise = cyc;
    tick(5);
    mon_clk = 1'b0;
    tick(5);
    for (int i = 0; i < 19; i++) mon_period(5, 5);
    in_nom = 1'b0;
    chk("nom_valid_count", mv_cnt, 19);
    chk("nom_meas_count", meas_count, 19);
    chk("nom_first_latency", first_valid - t_rise, 13);
    chk("nom_bad_pulses", nom_bad, 0);
    chk("nom_period", last_period, 10);
    chk("nom_high", last_high, 5);
    chk("nom_err", period_err, 0);
    chk("nom_stuck", stuck, 0);

    // tolerance boundaries: 11 and 9 pass, 12 flags
    mon_period(6, 5);
    mon_period(5, 4);
    mon_period(6, 6);
    mon_clk = 1'b1;
    tick(2);
    chk("tol_11_9_no_err", period_err, 0);
    tick(1);
    chk("tol_12_err", period_err, 1);
    chk("tol_12_period", period_o, 12);
    tick(2);
    mon_clk = 1'b0;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", period_err, 0);
    tick(2);
    mon_period(4, 4);
    mon_clk = 1'b1;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_vs_new_err", period_err, 1);
    chk("tol_8_period", period_o, 8);
    tick(2);
    mon_clk = 1'b0;
    tick(4);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // duty cycle 3/7 then 8/2
    for (int i = 0; i < 3; i++) mon_period(3, 7);
    mon_clk = 1'b1;
    tick(4);
    chk("duty3_period", last_period, 10);
    chk("duty3_high", last_high, 3);
    tick(4);
    mon_clk = 1'b0;
    tick(2);
    mon_clk = 1'b1;
    tick(4);
    chk("duty8_high", last_high, 8);
    chk("duty8_period", last_period, 10);
    chk("duty_err", period_err, 0);
    tick(1);
    mon_clk = 1'b0;
    tick(5);

    // stuck clock after good periods
    mon_period(5, 5);
    mon_period(5, 5);
    mon_clk = 1'b1;
    n = 0;
    mv_s = 0;
    while (stuck !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
      if (n == 5) mon_clk = 1'b0;
      if (n == 10) mv_s = mv_cnt;
    end
    chk("stuck_time", n, 1003);
    chk("stuck_no_valid", mv_cnt, mv_s);
    chk("stuck_no_err", period_err, 0);

    // recovery
    mv0 = mv_cnt;
    mon_clk = 1'b1;
    tick(2);
    chk("stuck_before_rise", stuck, 1);
    tick(1);
    chk("stuck_clear", stuck, 0);
    tick(2);
    mon_clk = 1'b0;
    tick(5);
    chk("recov_no_meas", mv_cnt - mv0, 0);
    mon_period(5, 5);
    mon_clk = 1'b1;
    tick(4);
    chk("recov_meas_count", mv_cnt - mv0, 2);
    chk("recov_period", last_period, 10);
    tick(1);
    mon_clk = 1'b0;
    tick(5);

    // disable mid-period, then re-enable
    mon_clk = 1'b1;
    tick(5);
    en = 1'b0;
    mv0 = mv_cnt;
    mc_d = int'(meas_count);
    mon_clk = 1'b0;
    tick(5);
    mon_period(5, 5);
    mon_period(5, 5);
    chk("dis_period_hold", period_o, 10);
    chk("dis_no_valid", mv_cnt - mv0, 0);
    chk("dis_count_hold", meas_count, mc_d);
    en = 1'b1;
    tick(2);
    mv0 = mv_cnt;
    mon_period(5, 5);
    chk("reen_first_rise_silent", mv_cnt - mv0, 0);
    mon_clk = 1'b1;
    tick(4);
    chk("reen_meas", mv_cnt - mv0, 1);
    chk("reen_period", last_period, 10);

    // asynchronous reset mid-measurement
    tick(1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async", {period_o, high_o, meas_count, meas_valid, period_err, stuck}, 64'd0);
    tick(1);
    rst = 1'b0;
    mon_clk = 1'b0;
    en = 1'b0;

    // slow clock, 1500-cycle period, TIMEOUT 2000
    en_slow = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      mon_slow = 1'b1;
      tick(750);
      mon_slow = 1'b0;
      tick(750);
    end
    mon_slow = 1'b1;
    tick(3);
    chk("slow_valid", s_valid, 1);
    tick(1);
    chk("slow_period", s_period, 1500);
    chk("slow_high", s_high, 750);
    chk("slow_stuck", s_stuck, 0);
    chk("slow_count", s_count, 2);
    chk("slow_err", s_err, 1);

    // 8-bit counter, 150-cycle period, TIMEOUT 200
    en_small = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      mon_small = 1'b1;
      tick(75);
      mon_small = 1'b0;
      tick(75);
    end
    mon_small = 1'b1;
    tick(3);
    chk("small_valid", m_valid, 1);
    tick(1);
    chk("small_period", m_period, 150);
    chk("small_high", m_high, 75);
    chk("small_err", m_err, 1);
    chk("small_stuck", m_stuck, 0);
    chk("small_count", m_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
